sobel_sequencer: RTL and testbench

SOBEL_SEQUENCER -- requirements
Module: sobel_sequencer

---
 rtl/sobel_seq_pkg.sv | 42 ++++
 rtl/sobel_seq_timer.sv | 43 ++++
 rtl/sobel_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sobel_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_seq_pkg.sv
// Shared types and register-map constants for the Sobel window sequencer.
package sobel_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RESULT = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_CLR    = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_SEQ_ERR = 2;
   localparam int STAT_TIMEOUT = 3;
   localparam int STAT_ROW_LSB = 4;

   localparam logic [1:0] ROWS_FULL = 2'd3;

   function automatic logic [31:0] pack_status(input logic       busy,
                                               input logic       done,
                                               input logic       seq_err,
                                               input logic       timeout,
                                               input logic [1:0] row_cnt);
      logic [31:0] s;
      s                     = 32'd0;
      s[STAT_BUSY]          = busy;
      s[STAT_DONE]          = done;
      s[STAT_SEQ_ERR]       = seq_err;
      s[STAT_TIMEOUT]       = timeout;
      s[STAT_ROW_LSB +: 2]  = row_cnt;
      return s;
   endfunction

endpackage

// File: rtl/sobel_seq_timer.sv
// WAIT-state cycle counter: expired_o is high during the TIMEOUT_CYCLES-th enabled cycle.
module sobel_seq_timer
   import sobel_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: saturates at LAST so a stalled enable never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/sobel_sequencer.sv
// Avalon-MM front end that collects three pixel rows, launches the Sobel datapath and
// captures its result, with sequencing-error and timeout reporting.
module sobel_sequencer
   import sobel_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int PIX_W          = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   output logic [9*PIX_W-1:0]   sobel_window,
   output logic                 sobel_start,
   input  logic                 sobel_done,
   input  logic [31:0]          sobel_result,
   output logic                 irq
);

   localparam int ROW_W = 3 * PIX_W;

   state_e             state_q, state_d;
   logic [1:0]         row_cnt_q, row_cnt_d;
   logic [9*PIX_W-1:0] rows_q, rows_d;
   logic [31:0]        result_q, result_d;
   logic               done_flag_q, done_flag_d;
   logic               seq_err_q, seq_err_d;
   logic               timeout_err_q, timeout_err_d;
   logic               irq_en_q, irq_en_d;

   logic               wr_s, data_wr_s, ctrl_wr_s;
   logic               clr_req_s, start_req_s, start_ok_s;
   logic               data_ok_s, data_err_s;
   logic [1:0]         row_cnt_eff_s;
   logic               expired_s;
   logic               unused_wd_s;

   assign wr_s        = chipselect && !write_n;
   assign data_wr_s   = wr_s && (address == ADDR_DATA);
   assign ctrl_wr_s   = wr_s && (address == ADDR_CTRL);
   assign clr_req_s   = ctrl_wr_s && writedata[CTRL_CLR];
   assign start_req_s = ctrl_wr_s && writedata[CTRL_START];
   // clr acts before start, so a combined clr+start sees an empty row buffer.
   assign row_cnt_eff_s = clr_req_s ? 2'd0 : row_cnt_q;
   assign start_ok_s  = start_req_s && (state_q == ST_IDLE) && (row_cnt_eff_s == ROWS_FULL);
   assign data_ok_s   = data_wr_s && (state_q == ST_IDLE) && (row_cnt_q != ROWS_FULL);
   assign data_err_s  = data_wr_s && !data_ok_s;
   assign unused_wd_s = ^writedata;

   sobel_seq_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i    (clk),
      .reset_i  (reset),
      .clear_i  (state_q != ST_WAIT),
      .enable_i (state_q == ST_WAIT),
      .expired_o(expired_s)
   );

   // Next-state and register-update logic for the FSM and the register file.
   always_comb begin
      state_d       = state_q;
      row_cnt_d     = row_cnt_q;
      rows_d        = rows_q;
      result_d      = result_q;
      done_flag_d   = done_flag_q;
      seq_err_d     = seq_err_q;
      timeout_err_d = timeout_err_q;
      irq_en_d      = irq_en_q;

      if (clr_req_s) begin
         done_flag_d   = 1'b0;
         seq_err_d     = 1'b0;
         timeout_err_d = 1'b0;
         row_cnt_d     = 2'd0;
      end else begin
         row_cnt_d     = row_cnt_q;
      end

      if (ctrl_wr_s) begin
         irq_en_d = writedata[CTRL_IRQ_EN];
      end else begin
         irq_en_d = irq_en_q;
      end

      if (data_ok_s) begin
         case (row_cnt_q)
            2'd0:    rows_d[ROW_W-1:0]         = writedata[ROW_W-1:0];
            2'd1:    rows_d[2*ROW_W-1:ROW_W]   = writedata[ROW_W-1:0];
            default: rows_d[3*ROW_W-1:2*ROW_W] = writedata[ROW_W-1:0];
         endcase
         row_cnt_d = row_cnt_q + 2'd1;
      end else begin
         rows_d = rows_q;
      end

      seq_err_d = seq_err_d | data_err_s | (start_req_s & ~start_ok_s);

      case (state_q)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_d     = ST_ISSUE;
               done_flag_d = 1'b0;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sobel_done) begin
               result_d    = sobel_result;
               done_flag_d = 1'b1;
               row_cnt_d   = 2'd0;
               state_d     = ST_IDLE;
            end else if (expired_s) begin
               timeout_err_d = 1'b1;
               row_cnt_d     = 2'd0;
               state_d       = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and register file.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         row_cnt_q     <= 2'd0;
         rows_q        <= '0;
         result_q      <= 32'd0;
         done_flag_q   <= 1'b0;
         seq_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         irq_en_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_cnt_q     <= row_cnt_d;
         rows_q        <= rows_d;
         result_q      <= result_d;
         done_flag_q   <= done_flag_d;
         seq_err_q     <= seq_err_d;
         timeout_err_q <= timeout_err_d;
         irq_en_q      <= irq_en_d;
      end
   end

   // Register read mux; DATA is write-only and start/clr always read back as zero.
   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_DATA:   readdata = 32'd0;
         ADDR_CTRL:   readdata = {30'd0, irq_en_q, 1'b0};
         ADDR_STATUS: readdata = pack_status(state_q != ST_IDLE, done_flag_q, seq_err_q,
                                             timeout_err_q, row_cnt_q);
         ADDR_RESULT: readdata = result_q;
         default:     readdata = 32'd0;
      endcase
   end

   assign sobel_window = rows_q;
   assign sobel_start  = (state_q == ST_ISSUE);
   assign irq          = done_flag_q && irq_en_q;

endmodule

// File: tb/tb_sobel_sequencer.sv
// Directed bench: register-access vector table plus hand-written start/done/timeout/reset sequences.
module tb_sobel_sequencer;

   localparam int PIX_W = 8;
   localparam int TMO   = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         address;
   logic               chipselect;
   logic               write_n;
   logic [31:0]        writedata;
   logic [31:0]        readdata;
   logic [9*PIX_W-1:0] sobel_window;
   logic               sobel_start;
   logic               sobel_done;
   logic [31:0]        sobel_result;
   logic               irq;

   int checks = 0;
   int errors = 0;

   sobel_sequencer #(.TIMEOUT_CYCLES(TMO), .PIX_W(PIX_W)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .sobel_window(sobel_window), .sobel_start(sobel_start), .sobel_done(sobel_done),
      .sobel_result(sobel_result), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        do_wr;
      logic [1:0]  wa;
      logic [31:0] wd;
      logic [1:0]  ra;
      logic [31:0] exp_rd;
      logic        chk_win;
      logic [71:0] exp_win;
      string       name;
   } vec_t;

   vec_t tbl[15];

   localparam logic [71:0] WIN_A = 72'h090807_060504_030201;
   localparam logic [71:0] WIN_B = 72'h333333_222222_111111;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
      address = a;
      #1;
      chk(name, {40'd0, readdata}, {40'd0, exp});
   endtask

   task automatic pulse_done(input logic [31:0] r);
      @(negedge clk);
      sobel_done   = 1'b1;
      sobel_result = r;
      @(posedge clk);
      #1;
      sobel_done   = 1'b0;
   endtask

   task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      wr(2'd0, a);
      wr(2'd0, b);
      wr(2'd0, c);
   endtask

   initial begin
      reset        = 1'b1;
      address      = 2'd0;
      chipselect   = 1'b0;
      write_n      = 1'b1;
      writedata    = 32'd0;
      sobel_done   = 1'b0;
      sobel_result = 32'd0;

      tbl[0]  = '{1'b1, 2'd0, 32'h030201, 2'd2, 32'h10, 1'b0, 72'd0,  "row1"};
      tbl[1]  = '{1'b1, 2'd0, 32'h060504, 2'd2, 32'h20, 1'b0, 72'd0,  "row2"};
      tbl[2]  = '{1'b1, 2'd1, 32'h1,      2'd2, 32'h24, 1'b0, 72'd0,  "start_2rows"};
      tbl[3]  = '{1'b1, 2'd0, 32'h090807, 2'd2, 32'h34, 1'b1, WIN_A,  "row3"};
      tbl[4]  = '{1'b1, 2'd0, 32'h0A0B0C, 2'd2, 32'h34, 1'b1, WIN_A,  "data_4th"};
      tbl[5]  = '{1'b1, 2'd1, 32'h4,      2'd2, 32'h00, 1'b0, 72'd0,  "clr"};
      tbl[6]  = '{1'b1, 2'd1, 32'h2,      2'd1, 32'h2,  1'b0, 72'd0,  "irq_en_set"};
      tbl[7]  = '{1'b1, 2'd1, 32'h0,      2'd1, 32'h0,  1'b0, 72'd0,  "irq_en_clr"};
      tbl[8]  = '{1'b1, 2'd0, 32'h111111, 2'd2, 32'h10, 1'b0, 72'd0,  "reload1"};
      tbl[9]  = '{1'b1, 2'd0, 32'h222222, 2'd2, 32'h20, 1'b0, 72'd0,  "reload2"};
      tbl[10] = '{1'b1, 2'd0, 32'h333333, 2'd2, 32'h30, 1'b1, WIN_B,  "reload3"};
      tbl[11] = '{1'b1, 2'd1, 32'h5,      2'd2, 32'h04, 1'b1, WIN_B,  "clr_start"};
      tbl[12] = '{1'b1, 2'd1, 32'h4,      2'd2, 32'h00, 1'b0, 72'd0,  "clr2"};
      tbl[13] = '{1'b0, 2'd0, 32'h0,      2'd0, 32'h0,  1'b0, 72'd0,  "data_read"};
      tbl[14] = '{1'b0, 2'd0, 32'h0,      2'd3, 32'h0,  1'b0, 72'd0,  "result_init"};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start", {71'd0, sobel_start}, 72'd0);
      chk("rst_irq",   {71'd0, irq}, 72'd0);
      reset = 1'b0;
      rd_chk(2'd2, 32'h0, "rst_status");
      rd_chk(2'd1, 32'h0, "rst_ctrl");
      chk("rst_window", sobel_window, 72'd0);

      // Register-access vectors
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].do_wr) wr(tbl[i].wa, tbl[i].wd);
         rd_chk(tbl[i].ra, tbl[i].exp_rd, tbl[i].name);
         if (tbl[i].chk_win) chk({tbl[i].name, "_win"}, sobel_window, tbl[i].exp_win);
      end

      // Normal operation, irq disabled
      load3(32'h030201, 32'h060504, 32'h090807);
      wr(2'd1, 32'h1);
      chk("start_pulse", {71'd0, sobel_start}, 72'd1);
      chk("win_row0", {48'd0, sobel_window[23:0]}, 72'h030201);
      @(posedge clk); #1;
      chk("start_one_cycle", {71'd0, sobel_start}, 72'd0);
      repeat (2) @(posedge clk); #1;
      rd_chk(2'd2, 32'h31, "busy_status");
      chk("win_stable", sobel_window, WIN_A);
      @(posedge clk); #1;
      pulse_done(32'h0000_00FF);
      rd_chk(2'd2, 32'h2, "done_status");
      rd_chk(2'd3, 32'hFF, "result");
      chk("irq_off", {71'd0, irq}, 72'd0);
      wr(2'd1, 32'h2);
      chk("irq_on", {71'd0, irq}, 72'd1);
      rd_chk(2'd3, 32'hFF, "result_reread");
      rd_chk(2'd2, 32'h2, "done_sticky");
      wr(2'd1, 32'h6);
      rd_chk(2'd2, 32'h0, "clr_done");
      chk("irq_cleared", {71'd0, irq}, 72'd0);
      pulse_done(32'h1234);
      rd_chk(2'd3, 32'hFF, "done_in_idle");
      rd_chk(2'd2, 32'h0, "done_in_idle_status");

      // Start while busy
      load3(32'h030201, 32'h060504, 32'h090807);
      wr(2'd1, 32'h3);
      wr(2'd1, 32'h3);
      rd_chk(2'd2, 32'h35, "busy_start");
      pulse_done(32'h77);
      rd_chk(2'd2, 32'h06, "busy_start_done");
      chk("busy_irq", {71'd0, irq}, 72'd1);
      wr(2'd1, 32'h6);

      // Timeout with no done
      load3(32'h030201, 32'h060504, 32'h090807);
      wr(2'd1, 32'h3);
      repeat (TMO) @(posedge clk);
      #1;
      rd_chk(2'd2, 32'h31, "tmo_last_wait");
      @(posedge clk); #1;
      rd_chk(2'd2, 32'h08, "tmo_status");
      chk("tmo_irq", {71'd0, irq}, 72'd0);
      wr(2'd1, 32'h4);

      // Done coincident with timer expiry
      load3(32'h030201, 32'h060504, 32'h090807);
      wr(2'd1, 32'h1);
      repeat (TMO) @(posedge clk);
      #1;
      rd_chk(2'd2, 32'h31, "coin_last_wait");
      sobel_done   = 1'b1;
      sobel_result = 32'hABCD;
      @(posedge clk); #1;
      sobel_done   = 1'b0;
      rd_chk(2'd2, 32'h02, "coin_status");
      rd_chk(2'd3, 32'hABCD, "coin_result");
      wr(2'd1, 32'h4);

      // Reset mid-operation, then a late done
      load3(32'h030201, 32'h060504, 32'h090807);
      wr(2'd1, 32'h3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_start", {71'd0, sobel_start}, 72'd0);
      reset = 1'b0;
      pulse_done(32'h5555);
      rd_chk(2'd2, 32'h0, "late_done_status");
      rd_chk(2'd3, 32'h0, "late_done_result");
      rd_chk(2'd1, 32'h0, "mid_rst_ctrl");
      chk("mid_rst_irq", {71'd0, irq}, 72'd0);
      chk("mid_rst_window", sobel_window, 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
